// File: rtl/parity_link_pkg.sv
// Shared types and constants for the parity link.
// FSM encoding, data/frame widths, parity bit position.
package parity_link_pkg;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = 9;
  localparam int PAR_BIT = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    DELIVER = 2'd2,
    FAIL    = 2'd3
  } arq_state_t;

endpackage

// File: rtl/parity_arq_ctrl_sat_counter.sv
// Saturating up-counter used for link statistics.
// Ports: clk, rst_n, inc -> count (sticks at all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/parity_arq_ctrl.sv
// ARQ controller: sends a byte, retries on parity error, delivers or drops.
// Ports: in_* request handshake, tx_* to sender, rx_* from receiver, out_* downstream, fail/stats.
import parity_link_pkg::*;

module parity_arq_ctrl #(
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_valid,
  output logic [2:0]         tx_attempt,
  input  logic [FRAME_W-1:0] rx_data,
  input  logic               rx_error,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               fail,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   drop_count
);

  localparam logic [2:0] MAX_A = 3'(MAX_RETRY);

  arq_state_t        state_q, state_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [2:0]        att_q, att_d;
  logic              err_inc, drop_inc;

  // Parity is already judged by the receiver.
  logic unused_par;
  assign unused_par = rx_data[PAR_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      out_q   <= '0;
      att_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      out_q   <= out_d;
      att_q   <= att_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    out_d     = out_q;
    att_d     = att_q;
    err_inc   = 1'b0;
    drop_inc  = 1'b0;
    in_ready  = 1'b0;
    tx_valid  = 1'b0;
    out_valid = 1'b0;
    fail      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          byte_d  = in_data;
          att_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (!rx_error) begin
          out_d   = rx_data[FRAME_W-1:PAR_BIT+1];
          state_d = DELIVER;
        end else begin
          err_inc = 1'b1;
          if (att_q == MAX_A) begin
            drop_inc = 1'b1;
            state_d  = FAIL;
          end else begin
            att_d = att_q + 3'd1;
          end
        end
      end
      DELIVER: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      FAIL: begin
        fail    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx_data    = byte_q;
  assign tx_attempt = att_q;
  assign out_data   = out_q;

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .count (drop_count)
  );

endmodule

// File: tb/tb_parity_arq_ctrl.sv
// Bench for parity_arq_ctrl with a behavioural sender/channel/receiver.
// Directed table, random traffic vs. transaction model, reset and saturation.
module tb_parity_arq_ctrl;

  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [2:0] tx_attempt;
  logic [8:0] rx_data;
  logic       rx_error;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       fail;
  logic [7:0] err_count;
  logic [7:0] drop_count;

  logic       b_in_valid = 1'b0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready;
  logic [7:0] b_tx_data;
  logic       b_tx_valid;
  logic [2:0] b_tx_attempt;
  logic [8:0] b_rx_data;
  logic       b_rx_error;
  logic       b_out_valid;
  logic [7:0] b_out_data;
  logic       b_fail;
  logic [1:0] b_err_count;
  logic [1:0] b_drop_count;
  logic       b_stuck = 1'b0;

  int  nerr_cur = 0;
  bit  noise = 1'b0;
  int  total = 0;
  int  bad = 0;
  int  m_err = 0;
  int  m_drop = 0;

  always #5 clk = ~clk;

  // Channel: even-parity frame, MSB flipped on the attempts chosen to fail.
  logic corrupt;
  assign corrupt = noise ||
    (tx_valid && (int'(tx_attempt) < nerr_cur));
  assign rx_data  = {tx_data, ^tx_data} ^ {corrupt, 8'h00};
  assign rx_error = ^rx_data;

  assign b_rx_data  = {b_tx_data, ^b_tx_data} ^ {b_stuck, 8'h00};
  assign b_rx_error = ^b_rx_data;

  parity_arq_ctrl #(.MAX_RETRY(MAXR), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_attempt(tx_attempt),
    .rx_data(rx_data), .rx_error(rx_error),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fail(fail), .err_count(err_count), .drop_count(drop_count)
  );

  parity_arq_ctrl #(.MAX_RETRY(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_attempt(b_tx_attempt),
    .rx_data(b_rx_data), .rx_error(b_rx_error),
    .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(1'b1),
    .fail(b_fail), .err_count(b_err_count),
    .drop_count(b_drop_count)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".in_ready"}, int'(in_ready), 1);
    chk({nm, ".tx_valid"}, int'(tx_valid), 0);
    chk({nm, ".tx_data"}, int'(tx_data), 0);
    chk({nm, ".tx_attempt"}, int'(tx_attempt), 0);
    chk({nm, ".out_valid"}, int'(out_valid), 0);
    chk({nm, ".out_data"}, int'(out_data), 0);
    chk({nm, ".fail"}, int'(fail), 0);
    chk({nm, ".err_count"}, int'(err_count), 0);
    chk({nm, ".drop_count"}, int'(drop_count), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic run_byte(input logic [7:0] d, input int nerr,
                          input int delay, input bit exp_fail,
                          input int exp_err, input int exp_drop);
    int nat;
    nat = exp_fail ? MAXR + 1 : nerr + 1;
    chk("accept.in_ready", int'(in_ready), 1);
    in_valid  = 1'b1;
    in_data   = d;
    nerr_cur  = nerr;
    out_ready = (delay == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    for (int a = 0; a < nat; a++) begin
      chk("send.tx_valid", int'(tx_valid), 1);
      chk("send.tx_attempt", int'(tx_attempt), a);
      chk("send.tx_data", int'(tx_data), int'(d));
      chk("send.in_ready", int'(in_ready), 0);
      chk("send.out_valid", int'(out_valid), 0);
      @(negedge clk);
    end
    chk("end.tx_valid", int'(tx_valid), 0);
    if (exp_fail) begin
      chk("drop.fail", int'(fail), 1);
      chk("drop.out_valid", int'(out_valid), 0);
      @(negedge clk);
      chk("drop.fail_once", int'(fail), 0);
    end else begin
      chk("dlv.fail", int'(fail), 0);
      noise = 1'b1;
      for (int k = 0; k < delay; k++) begin
        chk("hold.out_valid", int'(out_valid), 1);
        chk("hold.out_data", int'(out_data), int'(d));
        chk("hold.in_ready", int'(in_ready), 0);
        @(negedge clk);
      end
      noise = 1'b0;
      out_ready = 1'b1;
      chk("dlv.out_valid", int'(out_valid), 1);
      chk("dlv.out_data", int'(out_data), int'(d));
      @(negedge clk);
      chk("dlv.out_valid_low", int'(out_valid), 0);
    end
    chk("idle.in_ready", int'(in_ready), 1);
    chk("idle.err_count", int'(err_count), exp_err);
    chk("idle.drop_count", int'(drop_count), exp_drop);
    nerr_cur = 0;
  endtask

  typedef struct {
    logic [7:0] data;
    int         nerr;
    int         delay;
    bit         exp_fail;
    int         exp_err;
    int         exp_drop;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA5, 0, 0, 1'b0,  0, 0};
    tbl[1] = '{8'h5A, 2, 0, 1'b0,  2, 0};
    tbl[2] = '{8'h3C, 9, 0, 1'b1,  6, 1};
    tbl[3] = '{8'hC3, 0, 5, 1'b0,  6, 1};
    tbl[4] = '{8'h0F, 3, 1, 1'b0,  9, 1};
    tbl[5] = '{8'hF0, 4, 0, 1'b1, 13, 2};
    tbl[6] = '{8'h00, 1, 2, 1'b0, 14, 2};

    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    foreach (tbl[i])
      run_byte(tbl[i].data, tbl[i].nerr, tbl[i].delay,
               tbl[i].exp_fail, tbl[i].exp_err, tbl[i].exp_drop);

    m_err  = 14;
    m_drop = 2;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      int ne, dl;
      bit f;
      d  = 8'($urandom);
      ne = $urandom_range(0, 5);
      dl = $urandom_range(0, 3);
      f  = (ne > MAXR);
      m_err  += f ? MAXR + 1 : ne;
      m_drop += f ? 1 : 0;
      if (m_err > 255) m_err = 255;
      if (m_drop > 255) m_drop = 255;
      run_byte(d, ne, dl, f, m_err, m_drop);
    end

    // Reset during the second attempt of a retrying byte.
    in_valid = 1'b1;
    in_data  = 8'h77;
    nerr_cur = 9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid.tx_attempt", int'(tx_attempt), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    nerr_cur = 0;
    for (int k = 0; k < 3; k++) begin
      chk("after_rst.fail", int'(fail), 0);
      chk("after_rst.err", int'(err_count), 0);
      chk("after_rst.in_ready", int'(in_ready), 1);
      @(negedge clk);
    end

    // MAX_RETRY=0, 2-bit counters, permanently broken channel.
    b_stuck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int e;
      e = (i + 1 > 3) ? 3 : i + 1;
      chk("b.in_ready", int'(b_in_ready), 1);
      b_in_valid = 1'b1;
      b_in_data  = 8'(8'h11 * (i + 1));
      @(negedge clk);
      b_in_valid = 1'b0;
      chk("b.tx_valid", int'(b_tx_valid), 1);
      chk("b.tx_attempt", int'(b_tx_attempt), 0);
      @(negedge clk);
      chk("b.fail", int'(b_fail), 1);
      chk("b.out_valid", int'(b_out_valid), 0);
      @(negedge clk);
      chk("b.fail_once", int'(b_fail), 0);
      chk("b.err_count", int'(b_err_count), e);
      chk("b.drop_count", int'(b_drop_count), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
